// File: rtl/pll_ctrl_pkg.sv
// State encoding and elaboration helpers shared by the PLL bring-up controller.
// Declarations only: no latency, no flow control.
package pll_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      ENABLE    = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_e;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_bringup_ctrl_if.sv
// Bundle between the bring-up controller and the PLL wrapper / board logic.
// Level signals only; restart is a single-cycle pulse, no backpressure.
interface pll_bringup_ctrl_if
   import pll_ctrl_pkg::*;
#(
   parameter int NUM_OUT = 3
);
   logic               restart;
   logic               pll_lock;
   logic               pll_reset;
   logic [NUM_OUT-1:0] enclk;
   logic               ready;
   logic               fault;
   logic [STATE_W-1:0] state;
   logic [7:0]         relock_cnt;

   modport master (
      input  restart, pll_lock,
      output pll_reset, enclk, ready, fault, state, relock_cnt
   );

   modport slave (
      output restart, pll_lock,
      input  pll_reset, enclk, ready, fault, state, relock_cnt
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
// Latency 2 cycles; no flow control.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/pll_bringup_ctrl.sv
// PLL bring-up: reset pulse, lock wait/qualify, staggered clock enables, relock on loss.
// Lock seen 2 cycles after pll_lock, outputs registered (+1); no backpressure.
module pll_bringup_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int NUM_OUT             = 3,
   parameter int RST_CYCLES          = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int EN_GAP_CYCLES       = 8,
   parameter int MAX_RETRY           = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   pll_bringup_ctrl_if.master bus
);
   localparam int TMR_MAX = max_of(max_of(RST_CYCLES, LOCK_STABLE_CYCLES),
                                   max_of(LOCK_TIMEOUT_CYCLES, EN_GAP_CYCLES));
   localparam int TMR_W   = $clog2(TMR_MAX) + 1;
   localparam int RTY_W   = $clog2(MAX_RETRY + 1);

   logic               w_lock_s;

   state_e             r_state;
   logic [TMR_W-1:0]   r_tmr;
   logic [RTY_W-1:0]   r_retry;
   logic               r_pll_reset;
   logic [NUM_OUT-1:0] r_enclk;
   logic               r_ready;
   logic               r_fault;
   logic [7:0]         r_relock_cnt;

   sync_2ff u_lock_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (bus.pll_lock),
      .o_q     (w_lock_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RESET;
         r_tmr        <= '0;
         r_retry      <= '0;
         r_pll_reset  <= 1'b1;
         r_enclk      <= '0;
         r_ready      <= 1'b0;
         r_fault      <= 1'b0;
         r_relock_cnt <= '0;
      end else if (bus.restart) begin
         r_state     <= RESET;
         r_tmr       <= '0;
         r_retry     <= '0;
         r_pll_reset <= 1'b1;
         r_enclk     <= '0;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         case (r_state)
            RESET: begin
               r_pll_reset <= 1'b1;
               r_enclk     <= '0;
               r_ready     <= 1'b0;
               if (r_tmr == TMR_W'(RST_CYCLES - 1)) begin
                  r_state     <= WAIT_LOCK;
                  r_tmr       <= '0;
                  r_pll_reset <= 1'b0;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (w_lock_s) begin
                  r_state <= STABLE;
                  r_tmr   <= '0;
               end else if (r_tmr == TMR_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  r_tmr       <= '0;
                  r_retry     <= r_retry + RTY_W'(1);
                  r_pll_reset <= 1'b1;
                  if (r_retry == RTY_W'(MAX_RETRY - 1)) begin
                     r_state <= FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= RESET;
                  end
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            STABLE: begin
               // Count runs one past the threshold so enclk[0] lands on t+3+LOCK_STABLE_CYCLES.
               if (!w_lock_s) begin
                  r_state <= WAIT_LOCK;
                  r_tmr   <= '0;
               end else if (r_tmr == TMR_W'(LOCK_STABLE_CYCLES)) begin
                  r_state <= ENABLE;
                  r_tmr   <= '0;
                  r_retry <= '0;
                  r_enclk <= NUM_OUT'(1);
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            ENABLE, RUN: begin
               if (!w_lock_s) begin
                  r_state     <= RESET;
                  r_tmr       <= '0;
                  r_pll_reset <= 1'b1;
                  r_enclk     <= '0;
                  r_ready     <= 1'b0;
                  if (r_relock_cnt != 8'hFF)
                     r_relock_cnt <= r_relock_cnt + 8'd1;
               end else if (r_state == ENABLE) begin
                  // Enables fill from bit 0 upward; the top bit set means all are on.
                  if (r_tmr == TMR_W'(EN_GAP_CYCLES - 1)) begin
                     r_tmr <= '0;
                     if (r_enclk[NUM_OUT-1]) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                     end else begin
                        r_enclk <= (r_enclk << 1) | NUM_OUT'(1);
                     end
                  end else begin
                     r_tmr <= r_tmr + TMR_W'(1);
                  end
               end
            end
            FAULT: begin
               r_pll_reset <= 1'b1;
               r_fault     <= 1'b1;
               r_enclk     <= '0;
               r_ready     <= 1'b0;
            end
            default: begin
               r_state     <= RESET;
               r_tmr       <= '0;
               r_pll_reset <= 1'b1;
               r_enclk     <= '0;
               r_ready     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pll_reset  = r_pll_reset;
   assign bus.enclk      = r_enclk;
   assign bus.ready      = r_ready;
   assign bus.fault      = r_fault;
   assign bus.state      = r_state;
   assign bus.relock_cnt = r_relock_cnt;
endmodule

// File: tb/tb_pll_bringup_ctrl.sv
// Bench for pll_bringup_ctrl: expected output transitions are queued by the stimulus,
// a monitor compares every observed output change against the queue head.
module tb_pll_bringup_ctrl;
   import pll_ctrl_pkg::*;

   typedef struct {
      int         cyc;
      logic       pr;
      logic [2:0] en;
      logic       rdy;
      logic       flt;
      logic [2:0] st;
      logic [7:0] rc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   logic [13:0] mon_last;
   bit   mon_first = 1'b1;

   pll_bringup_ctrl_if #(.NUM_OUT(3)) bus ();

   pll_bringup_ctrl #(
      .NUM_OUT             (3),
      .RST_CYCLES          (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (64),
      .EN_GAP_CYCLES       (2),
      .MAX_RETRY           (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input logic pr, input logic [2:0] en, input logic rdy,
                       input logic flt, input logic [2:0] st, input int rc);
      exp_t e;
      e.cyc = c; e.pr = pr; e.en = en; e.rdy = rdy; e.flt = flt; e.st = st; e.rc = 8'(rc);
      q.push_back(e);
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: any change on the functional outputs must match the next queued transition.
   initial begin
      logic [13:0] key;
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         key = {bus.pll_reset, bus.enclk, bus.ready, bus.fault, bus.relock_cnt};
         if (mon_first || key !== mon_last) begin
            mon_first = 1'b0;
            mon_last  = key;
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change cyc=%0d pr=%b en=%b rdy=%b flt=%b st=%0d rc=%0d",
                        cyc, bus.pll_reset, bus.enclk, bus.ready, bus.fault, bus.state, bus.relock_cnt);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.pr !== bus.pll_reset || e.en !== bus.enclk ||
                   e.rdy !== bus.ready || e.flt !== bus.fault || e.st !== bus.state ||
                   e.rc !== bus.relock_cnt) begin
                  bad++;
                  $display("FAIL event got cyc=%0d pr=%b en=%b rdy=%b flt=%b st=%0d rc=%0d exp cyc=%0d pr=%b en=%b rdy=%b flt=%b st=%0d rc=%0d",
                           cyc, bus.pll_reset, bus.enclk, bus.ready, bus.fault, bus.state, bus.relock_cnt,
                           e.cyc, e.pr, e.en, e.rdy, e.flt, e.st, e.rc);
               end
            end
         end
      end
   end

   initial begin
      int a;
      int rc;
      rst_n        = 1'b0;
      bus.restart  = 1'b0;
      bus.pll_lock = 1'b0;

      // Reset state, then normal bring-up: lock sampled high at t=13.
      push(1,  1, 3'b000, 0, 0, RESET,     0);
      push(6,  0, 3'b000, 0, 0, WAIT_LOCK, 0);
      push(24, 0, 3'b001, 0, 0, ENABLE,    0);
      push(26, 0, 3'b011, 0, 0, ENABLE,    0);
      push(28, 0, 3'b111, 0, 0, ENABLE,    0);
      push(30, 0, 3'b111, 1, 0, RUN,       0);
      goto(2);  rst_n = 1'b1;
      goto(12); bus.pll_lock = 1'b1;

      // Lock loss in RUN, then relock (t=51).
      push(43, 1, 3'b000, 0, 0, RESET,     1);
      push(47, 0, 3'b000, 0, 0, WAIT_LOCK, 1);
      push(62, 0, 3'b001, 0, 0, ENABLE,    1);
      push(64, 0, 3'b011, 0, 0, ENABLE,    1);
      push(66, 0, 3'b111, 0, 0, ENABLE,    1);
      push(68, 0, 3'b111, 1, 0, RUN,       1);
      goto(40); bus.pll_lock = 1'b0;
      goto(50); bus.pll_lock = 1'b1;

      // Restart with lock low, one-cycle glitch in STABLE, then restart during ENABLE.
      push(71,  1, 3'b000, 0, 0, RESET,     1);
      push(75,  0, 3'b000, 0, 0, WAIT_LOCK, 1);
      push(97,  0, 3'b001, 0, 0, ENABLE,    1);
      push(98,  1, 3'b000, 0, 0, RESET,     1);
      push(102, 0, 3'b000, 0, 0, WAIT_LOCK, 1);
      push(112, 0, 3'b001, 0, 0, ENABLE,    1);
      push(114, 0, 3'b011, 0, 0, ENABLE,    1);
      push(116, 0, 3'b111, 0, 0, ENABLE,    1);
      push(118, 0, 3'b111, 1, 0, RUN,       1);
      goto(70); bus.restart = 1'b1; bus.pll_lock = 1'b0;
      goto(71); bus.restart = 1'b0;
      goto(78); bus.pll_lock = 1'b1;
      goto(84); bus.pll_lock = 1'b0;
      goto(85); bus.pll_lock = 1'b1;
      goto(97); bus.restart = 1'b1;
      goto(98); bus.restart = 1'b0;

      // 256 further lock losses, each a one-cycle drop just after enclk[0] rises.
      for (int k = 0; k < 256; k++) begin
         a  = 120 + 17 * k;
         rc = (k + 2 > 255) ? 255 : k + 2;
         push(a + 3,  1, 3'b000, 0, 0, RESET,     rc);
         push(a + 7,  0, 3'b000, 0, 0, WAIT_LOCK, rc);
         push(a + 17, 0, 3'b001, 0, 0, ENABLE,    rc);
         push(a + 19, 0, 3'b011, 0, 0, ENABLE,    rc);
         goto(a);     bus.pll_lock = 1'b0;
         goto(a + 1); bus.pll_lock = 1'b1;
      end
      push(4476, 0, 3'b111, 0, 0, ENABLE, 255);
      push(4478, 0, 3'b111, 1, 0, RUN,    255);

      // Asynchronous reset mid-RUN: outputs must be at reset values before the next edge.
      push(4491, 1, 3'b000, 0, 0, RESET, 0);
      goto(4490);
      #2 rst_n = 1'b0; bus.pll_lock = 1'b0;
      #1;
      total++;
      if (bus.pll_reset !== 1'b1 || bus.enclk !== 3'b000 || bus.ready !== 1'b0 ||
          bus.fault !== 1'b0 || bus.state !== 3'(RESET) || bus.relock_cnt !== 8'd0) begin
         bad++;
         $display("FAIL async_rst got pr=%b en=%b rdy=%b flt=%b st=%0d rc=%0d exp pr=1 en=000 rdy=0 flt=0 st=0 rc=0",
                  bus.pll_reset, bus.enclk, bus.ready, bus.fault, bus.state, bus.relock_cnt);
      end

      // Lock held low: two timeouts into FAULT, restart clears it, retry count restarts.
      push(4499, 0, 3'b000, 0, 0, WAIT_LOCK, 0);
      push(4563, 1, 3'b000, 0, 0, RESET,     0);
      push(4567, 0, 3'b000, 0, 0, WAIT_LOCK, 0);
      push(4631, 1, 3'b000, 0, 1, FAULT,     0);
      push(4641, 1, 3'b000, 0, 0, RESET,     0);
      push(4645, 0, 3'b000, 0, 0, WAIT_LOCK, 0);
      push(4709, 1, 3'b000, 0, 0, RESET,     0);
      push(4713, 0, 3'b000, 0, 0, WAIT_LOCK, 0);
      goto(4495); rst_n = 1'b1;
      goto(4640); bus.restart = 1'b1;
      goto(4641); bus.restart = 1'b0;
      goto(4720);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL missing_events got %0d unconsumed exp 0 (next cyc=%0d)", q.size(), q[0].cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pll_bringup_ctrl.md
# pll_bringup_ctrl

Sequences the on-chip PLL of the UVC design: holds it in reset for a defined pulse, waits for lock, qualifies lock stability, then releases the gated clock outputs one at a time. It monitors lock for loss and re-runs the sequence automatically. It runs on the free-running board reference clock and sits between the board reset logic and the PLL wrapper's `reset`, `lock` and `enclk0..2` pins. `ready` gates the rest of the design out of reset.

## Interface
- `NUM_OUT`, 3: number of gated PLL outputs driven (1..7).
- `RST_CYCLES`, 16: PLL reset pulse width in clk cycles (≥2).
- `LOCK_STABLE_CYCLES`, 1024: continuous lock required before enabling outputs (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: max wait for lock after reset release (≥2).
- `EN_GAP_CYCLES`, 8: spacing between successive output enables (≥1).
- `MAX_RETRY`, 3: consecutive lock timeouts before fault (≥1).

Ports:
- `clk` in 1: free-running reference clock (50 MHz). One clock only.
- `rst_n` in 1: asynchronous, active-low reset.
- `restart` in 1: single-cycle pulse; forces a new bring-up from any state and clears fault.
- `pll_lock` in 1: PLL lock, asynchronous to clk.
- `pll_reset` out 1: active-high PLL reset.
- `enclk` out NUM_OUT: per-output clock enable; bit i drives `enclk<i>`.
- `ready` out 1: all outputs enabled and lock qualified.
- `fault` out 1: retries exhausted. Sticky until `restart` or `rst_n`.
- `state` out 3: current FSM state encoding, for debug.
- `relock_cnt` out 8: number of lock losses seen after first `ready`. Saturates at 255.

## Operation
- `pll_lock` passes through a 2-FF synchroniser to give `lock_s`. Lock sees 2 cycles of latency.
- Reset values: `pll_reset`=1, `enclk`=0, `ready`=0, `fault`=0, `state`=RESET, `relock_cnt`=0, retry count 0. All outputs are registered.
- State RESET: `pll_reset`=1 and all `enclk`=0. After RST_CYCLES cycles, go to WAIT_LOCK.
- State WAIT_LOCK: `pll_reset`=0 and the timer runs.
  - If `lock_s`=1, go to STABLE.
  - If the timer reaches LOCK_TIMEOUT_CYCLES, increment retry. If retry then equals MAX_RETRY, go to FAULT; otherwise go to RESET.
- State STABLE: counts consecutive cycles with `lock_s`=1.
  - If `lock_s` drops, go back to WAIT_LOCK with a fresh timer. Retry count is unchanged.
  - When the count reaches LOCK_STABLE_CYCLES, go to ENABLE and clear retry.
- State ENABLE: asserts `enclk[0]` on entry and `enclk[i]` i·EN_GAP_CYCLES cycles later. Enables are cumulative.
  - EN_GAP_CYCLES after `enclk[NUM_OUT-1]` is asserted, go to RUN.
- State RUN: `ready`=1.
- Lock loss in ENABLE or RUN (`lock_s`=0):
  - Next cycle: all `enclk`=0, `ready`=0, state RESET.
  - `relock_cnt` increments, saturating at 255.
- State FAULT: `pll_reset`=1, `enclk`=0, `fault`=1. The block stays here until `restart`.
- `restart` has priority over every other transition. Next cycle: RESET, with timers and retry cleared, `fault`=0, `enclk`=0 and `ready`=0. `relock_cnt` is kept.
- Counters: one shared timer of width `$clog2(max(all cycle params))+1`. It clears on every state change.

## Timing
- `pll_reset` is high for exactly RST_CYCLES cycles per RESET visit. After `rst_n` deasserts, the first RESET visit counts from the first clk edge.
- Let t be the clk edge at which `pll_lock` is first sampled high in WAIT_LOCK and stays high. Then:
  - `enclk[i]` rises at t+3+LOCK_STABLE_CYCLES+i·EN_GAP_CYCLES.
  - `ready` rises at t+3+LOCK_STABLE_CYCLES+NUM_OUT·EN_GAP_CYCLES.
- Lock loss to `enclk`/`ready` low: 3 cycles from the `pll_lock` falling sample (2 synchroniser + 1 register).
- `rst_n` assertion mid-sequence: all outputs take their reset values asynchronously, with no glitch on `enclk`.

## Structure
- A shared package `pll_ctrl_pkg` holds the state enum (RESET, WAIT_LOCK, STABLE, ENABLE, RUN, FAULT) and the 3-bit encoding exported on `state`.
- Natural sub-module: `sync_2ff`, a single-bit synchroniser for `pll_lock`. It is reusable by other blocks.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, EN_GAP_CYCLES=2, MAX_RETRY=2, NUM_OUT=3.

1. **Normal bring-up.**
   - Stimulus: release `rst_n`; `pll_lock` rises at t.
   - Response: `pll_reset` is high for 4 cycles. `enclk` bits rise at t+11, t+13 and t+15. `ready` rises at t+17.
2. **Lock glitch in STABLE.**
   - Stimulus: `pll_lock` low for 1 cycle after 5 stable cycles.
   - Response: return to WAIT_LOCK, no `enclk` asserted. Stable count restarts, so `ready` is delayed by the glitch.
3. **Timeout and fault.**
   - Stimulus: `pll_lock` held low.
   - Response: two RESET pulses of 4 cycles, 64 cycles apart after reset. Then `fault`=1, `pll_reset`=1, `state`=FAULT.
   - Follow-up: a `restart` pulse clears `fault` and issues a new 4-cycle reset.
4. **Lock loss in RUN.**
   - Stimulus: drop `pll_lock` while in RUN.
   - Response: `enclk`=0 and `ready`=0 three cycles later, `relock_cnt`=1, new `pll_reset` pulse. Re-lock reaches `ready` again.
5. **Restart during ENABLE.**
   - Stimulus: `restart` after `enclk[0]` rises.
   - Response: next cycle `enclk`=0 and `pll_reset`=1; `relock_cnt` unchanged.
6. **Saturation and async reset.**
   - Stimulus: 256 lock losses.
   - Response: `relock_cnt`=255 holds.
   - Follow-up: assert `rst_n` mid-RUN; all outputs are at reset values before the next clk edge.
